ysyx_22040000_pipe_reg: RTL and testbench
=========================================

Name: ysyx_22040000_pipe_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid buffer. It is the successor to the plain enable register and sits between NPC pipeline stages (IFU->IDU, IDU->EXU, EXU->LSU). It gives full-throughput back-pressure and lets the redirect logic kill in-flight instructions.

Parameters:
WIDTH, 32, payload width in bits (>=1).
RESET_VAL, 0, value loaded into the output payload register on reset.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
flush  input  1  kill all held entries at the next edge.
in_valid  input  1  upstream has a payload.
in_ready  output  1  stage can accept a payload this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  stage presents a payload.
out_ready  input  1  downstream accepts the payload this cycle.
out_data  output  WIDTH  presented payload.
occupancy  output  2  number of held entries (0..2).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=RESET_VAL, skid entry invalid, occupancy=0. in_ready=1 on the cycle after reset (SKID=1).
- Handshakes:
  - Accept occurs when in_valid && in_ready at the edge.
  - Issue occurs when out_valid && out_ready at the edge.
  - in_valid may be driven without waiting for in_ready.
  - in_data is sampled only on accept.
- Storage: main entry (data_q/valid_q) drives out_data/out_valid directly from flops, with no combinational in->out path. Skid entry (skid_q/skid_v) exists only when SKID=1.
- Ordering: strict FIFO order. No payload is lost or duplicated unless it is flushed.
- SKID=1 next state:
  - in_ready = !skid_v, driven from a flop.
  - Main empty or issuing: main loads skid_q if skid_v (skid_v clears, or reloads from the input if an accept happens the same cycle). Otherwise main loads in_data if accepting. Otherwise valid_q=0.
  - Main full and not issuing: an accept writes the skid entry; skid_v=1.
  - Simultaneous accept and issue with occupancy 1: in_data goes to main and occupancy stays 1.
  - Occupancy 2 with issue and no accept: skid moves to main and occupancy becomes 1.
- SKID=0:
  - in_ready = !valid_q || out_ready (combinational).
  - Accept loads main. Issue without accept clears valid_q.
  - occupancy is 0 or 1.
- out_data when out_valid=0: holds its last value. It does not change until the next load.
- flush:
  - Next edge: valid_q=0, skid_v=0, occupancy=0.
  - A payload accepted in the flush cycle is discarded.
  - An issue in the flush cycle still counts downstream, because it was presented before the flush took effect.
  - The cycle after a flush: in_ready=1.
- Priority: rst > flush > normal operation.
- Reset mid-transfer: all held payloads are dropped and there is no partial update.
- occupancy = valid_q + skid_v, taken from the flops.
- Invariant (verification assertion): skid_v implies valid_q.

Decomposition:
- Shared package ysyx_22040000_pkg holds the handshake typedef (valid, ready), the OCC_W=2 constant and the default XLEN=32 used for WIDTH at instantiation.
- Sub-module: use ysyx_22040000_Reg (WIDTH, RESET_VAL) for the data_q and skid_q payload registers, with wen = the load condition.
- Valid bits and occupancy are inline sequential logic.

Test Plan:
1. Reset with rst=1 for 2 cycles, RESET_VAL=32'hDEAD_BEEF -> out_valid=0, out_data=32'hDEAD_BEEF, occupancy=0, in_ready=1.
2. Stream 0x1..0x8 with in_valid=1 and out_ready=1 constantly -> one accept and one issue per cycle, out_data 0x1..0x8 in order, one cycle latency, occupancy stays 1.
3. Hold out_ready=0 while sending 0xA, 0xB, 0xC:
   - 0xA lands in main, 0xB in skid, occupancy=2, in_ready=0, 0xC is held upstream.
   - Release out_ready -> outputs 0xA, 0xB, 0xC, with no loss or duplicate.
4. Set occupancy=2, then assert flush together with in_valid (0x55) -> next cycle out_valid=0, occupancy=0, in_ready=1, and 0x55 never appears at the output.
5. Assert rst during a stalled transfer (occupancy=2) -> next cycle all state is at reset values. A following stream of 0x10, 0x11 outputs only 0x10, 0x11.
6. SKID=0 instance, random in_valid/out_ready over 1000 cycles against a scoreboard:
   - Order is preserved.
   - in_ready == !out_valid || out_ready in every cycle.
   - occupancy <= 1.

Source files
------------

// File: rtl/ysyx_22040000_pipe_reg_pkg.sv
// Shared definitions for the NPC pipeline stage registers.
package ysyx_22040000_pkg;

  localparam int XLEN  = 32;
  localparam int OCC_W = 2;

  // One side of a valid/ready handshake.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // Number of held entries from the main and skid valid bits.
  function automatic logic [OCC_W-1:0] occ_count(input logic v_main, input logic v_skid);
    return {1'b0, v_main} + {1'b0, v_skid};
  endfunction

endpackage

// File: rtl/ysyx_22040000_Reg.sv
// Payload register with synchronous reset and write enable.
module ysyx_22040000_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Capture din on wen, otherwise hold the stored payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end else begin
      dout <= dout;
    end
  end

endmodule

// File: rtl/ysyx_22040000_pipe_reg_chk.sv
// Structural invariants of the pipeline stage register.
module ysyx_22040000_pipe_reg_chk #(
  parameter bit SKID = 1'b1
) (
  input logic       clk,
  input logic       rst,
  input logic       valid_q,
  input logic       skid_v,
  input logic [1:0] occupancy
);

  // The skid entry only ever fills behind an occupied main entry.
  a_skid_needs_main: assert property (@(posedge clk) disable iff (rst) skid_v |-> valid_q);

  // Without a skid entry the stage holds at most one payload.
  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    occupancy <= (SKID ? 2'd2 : 2'd1));

endmodule

// File: rtl/ysyx_22040000_pipe_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// out_valid/out_data come straight from flops; with SKID=1 in_ready is registered too.
module ysyx_22040000_pipe_reg
  import ysyx_22040000_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  hs_t              in_hs_s;
  hs_t              out_hs_s;
  logic             valid_q;
  logic             skid_v;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_r;
  logic             accept_s;
  logic             issue_s;
  logic             main_free_s;
  logic             valid_nx_s;
  logic             skid_v_nx_s;
  logic             data_wen_s;
  logic             skid_wen_s;
  logic [WIDTH-1:0] data_din_s;

  assign in_ready    = SKID ? in_ready_r : (!valid_q || out_ready);
  assign in_hs_s     = '{valid: in_valid, ready: in_ready};
  assign out_hs_s    = '{valid: valid_q, ready: out_ready};
  assign accept_s    = in_hs_s.valid && in_hs_s.ready;
  assign issue_s     = out_hs_s.valid && out_hs_s.ready;
  // Main entry can take a new payload when it is empty or leaving this cycle.
  assign main_free_s = !valid_q || out_ready;

  // Next-state selection for the main and skid entries.
  always_comb begin
    valid_nx_s  = valid_q;
    skid_v_nx_s = skid_v;
    data_wen_s  = 1'b0;
    skid_wen_s  = 1'b0;
    data_din_s  = in_data;
    if (flush) begin
      // Payload registers keep their contents so out_data holds its last value.
      valid_nx_s  = 1'b0;
      skid_v_nx_s = 1'b0;
    end else if (SKID) begin
      if (main_free_s) begin
        if (skid_v) begin
          // Older skid payload moves forward first to keep FIFO order.
          data_wen_s  = 1'b1;
          data_din_s  = skid_q;
          valid_nx_s  = 1'b1;
          skid_v_nx_s = accept_s;
          skid_wen_s  = accept_s;
        end else if (accept_s) begin
          data_wen_s  = 1'b1;
          valid_nx_s  = 1'b1;
          skid_v_nx_s = 1'b0;
        end else begin
          valid_nx_s  = 1'b0;
          skid_v_nx_s = 1'b0;
        end
      end else begin
        if (accept_s) begin
          skid_wen_s  = 1'b1;
          skid_v_nx_s = 1'b1;
        end else begin
          skid_v_nx_s = skid_v;
        end
      end
    end else begin
      skid_v_nx_s = 1'b0;
      if (accept_s) begin
        data_wen_s = 1'b1;
        valid_nx_s = 1'b1;
      end else if (issue_s) begin
        valid_nx_s = 1'b0;
      end else begin
        valid_nx_s = valid_q;
      end
    end
  end

  // Valid bits and the registered in_ready follow the selected next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      valid_q    <= valid_nx_s;
      skid_v     <= skid_v_nx_s;
      in_ready_r <= !skid_v_nx_s;
    end
  end

  ysyx_22040000_Reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_data_reg (
    .clk (clk),
    .rst (rst),
    .wen (data_wen_s),
    .din (data_din_s),
    .dout(data_q)
  );

  generate
    if (SKID) begin : g_skid
      ysyx_22040000_Reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_skid_reg (
        .clk (clk),
        .rst (rst),
        .wen (skid_wen_s),
        .din (in_data),
        .dout(skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = data_q;
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occupancy = occ_count(valid_q, skid_v);

  ysyx_22040000_pipe_reg_chk #(
    .SKID(SKID)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .valid_q  (valid_q),
    .skid_v   (skid_v),
    .occupancy(occupancy)
  );

endmodule

// File: tb/tb_ysyx_22040000_pipe_reg.sv
// Self-checking bench: directed scenarios plus random streams against a queue model.
module tb_ysyx_22040000_pipe_reg;

  localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RV0 = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic        flush0, in_valid0, out_ready0;
  logic [31:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  occupancy0;

  logic [31:0] mq[$];
  logic [31:0] m0q[$];
  logic [31:0] obs[$];
  logic [31:0] mlast, m0last;
  int errors = 0;
  int checks = 0;

  ysyx_22040000_pipe_reg #(.WIDTH(32), .RESET_VAL(RV1), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy));

  ysyx_22040000_pipe_reg #(.WIDTH(32), .RESET_VAL(RV0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0));

  // Free-running clock.
  always #5 clk = ~clk;

  // One clock cycle: advance both FIFO models by the handshake rules and log DUT issues.
  task automatic tick();
    bit a1, i1, a0, i0, r, f1, f0;
    logic [31:0] d1, d0;
    a1 = in_valid && (mq.size() < 2);
    i1 = (mq.size() > 0) && out_ready;
    a0 = in_valid0 && ((m0q.size() == 0) || out_ready0);
    i0 = (m0q.size() > 0) && out_ready0;
    d1 = in_data; d0 = in_data0; r = rst; f1 = flush; f0 = flush0;
    if (out_valid && out_ready) obs.push_back(out_data);
    @(posedge clk);
    if (r) begin mq.delete(); mlast = RV1; end
    else if (f1) mq.delete();
    else begin
      if (i1) void'(mq.pop_front());
      if (a1) mq.push_back(d1);
    end
    if (mq.size() > 0) mlast = mq[0];
    if (r) begin m0q.delete(); m0last = RV0; end
    else if (f0) m0q.delete();
    else begin
      if (i0) void'(m0q.pop_front());
      if (a0) m0q.push_back(d0);
    end
    if (m0q.size() > 0) m0last = m0q[0];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== RV1) begin errors++; $display("FAIL reset_out_data: got %h want %h", out_data, RV1); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset0_out_valid: got %b want 0", out_valid0); end
    checks++; if (out_data0 !== RV0) begin errors++; $display("FAIL reset0_out_data: got %h want %h", out_data0, RV0); end
  endtask

  task automatic test_stream();
    obs.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin errors++; $display("FAIL stream_data: got v=%b d=%h want v=1 d=%h", out_valid, out_data, 32'(i)); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_occ: got occ=%0d rdy=%b want occ=1 rdy=1", occupancy, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    checks++; if (obs.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", obs.size()); end
    for (int k = 0; k < obs.size() && k < 8; k++) begin
      checks++; if (obs[k] !== 32'(k + 1)) begin errors++; $display("FAIL stream_order[%0d]: got %h want %h", k, obs[k], 32'(k + 1)); end
    end
  endtask

  task automatic test_backpressure();
    obs.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    checks++; if (occupancy !== 2'd1 || out_data !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL bp_first: got occ=%0d d=%h rdy=%b want 1 a 1", occupancy, out_data, in_ready); end
    in_data = 32'hB;
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want 2 0 a", occupancy, in_ready, out_data); end
    in_data = 32'hC;
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin errors++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%h want 2 0 a", occupancy, in_ready, out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got d=%h occ=%0d rdy=%b want b 1 1", out_data, occupancy, in_ready); end
    tick();
    checks++; if (out_data !== 32'hC || occupancy !== 2'd1) begin errors++; $display("FAIL bp_last: got d=%h occ=%0d want c 1", out_data, occupancy); end
    in_valid = 1'b0;
    tick();
    checks++; if (obs.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", obs.size()); end
    else begin
      checks++; if (obs[0] !== 32'hA || obs[1] !== 32'hB || obs[2] !== 32'hC) begin errors++; $display("FAIL bp_order: got %h %h %h want a b c", obs[0], obs[1], obs[2]); end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h21; tick();
    in_data = 32'h22; tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got occ=%0d want 2", occupancy); end
    flush = 1'b1; in_data = 32'h55; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got v=%b occ=%0d rdy=%b want 0 0 1", out_valid, occupancy, in_ready); end
    checks++; if (out_data !== 32'h21) begin errors++; $display("FAIL flush_hold: got %h want 21", out_data); end
    obs.delete(); out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0 || obs.size() != 0) begin errors++; $display("FAIL flush_leak: got v=%b issues=%0d want 0 0", out_valid, obs.size()); end
    // occupancy 1, flush with a same-cycle issue and accept
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h30; tick();
    flush = 1'b1; out_ready = 1'b1; in_data = 32'h56; tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_issue_state: got v=%b occ=%0d want 0 0", out_valid, occupancy); end
    checks++; if (obs.size() != 1 || obs[0] !== 32'h30) begin errors++; $display("FAIL flush_issue_count: got n=%0d first=%h want n=1 first=30", obs.size(), (obs.size() > 0) ? obs[0] : 32'h0); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h40; tick();
    in_data = 32'h41; tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL rstmid_fill: got occ=%0d want 2", occupancy); end
    rst = 1'b1; in_data = 32'h42; tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== RV1) begin errors++; $display("FAIL rstmid_state: got v=%b occ=%0d rdy=%b d=%h want 0 0 1 %h", out_valid, occupancy, in_ready, out_data, RV1); end
    obs.delete(); out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h10; tick();
    in_data = 32'h11; tick();
    in_valid = 1'b0; tick(); tick();
    checks++; if (obs.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", obs.size()); end
    else begin
      checks++; if (obs[0] !== 32'h10 || obs[1] !== 32'h11) begin errors++; $display("FAIL rstmid_order: got %h %h want 10 11", obs[0], obs[1]); end
    end
  endtask

  task automatic test_random_skid();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0) ? 1'b1 : (n[6] ? 1'b1 : 1'b0);
      in_data   = $urandom;
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      checks++; if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size())) begin errors++; $display("FAIL rand1_state@%0d: got v=%b occ=%0d want v=%b occ=%0d", n, out_valid, occupancy, mq.size() > 0, mq.size()); end
      checks++; if (out_data !== mlast) begin errors++; $display("FAIL rand1_data@%0d: got %h want %h", n, out_data, mlast); end
      checks++; if (in_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rand1_ready@%0d: got %b want %b", n, in_ready, mq.size() < 2); end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_skid0_random();
    for (int n = 0; n < 1000; n++) begin
      in_valid0  = $urandom_range(0, 1);
      out_ready0 = $urandom_range(0, 1);
      in_data0   = $urandom;
      #1;
      checks++; if (in_ready0 !== ((m0q.size() == 0) || out_ready0)) begin errors++; $display("FAIL rand0_ready@%0d: got %b want %b", n, in_ready0, (m0q.size() == 0) || out_ready0); end
      checks++; if (out_valid0 !== (m0q.size() > 0) || occupancy0 !== 2'(m0q.size()) || occupancy0 > 2'd1) begin errors++; $display("FAIL rand0_state@%0d: got v=%b occ=%0d want v=%b occ=%0d", n, out_valid0, occupancy0, m0q.size() > 0, m0q.size()); end
      checks++; if (out_data0 !== m0last) begin errors++; $display("FAIL rand0_data@%0d: got %h want %h", n, out_data0, m0last); end
      tick();
    end
    in_valid0 = 1'b0; out_ready0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = 32'h0;
    mlast = RV1; m0last = RV0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_skid();
    test_skid0_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
